gravador_resultados: RTL and testbench
======================================

Name: gravador_resultados

Overview:
- Writer-side counterpart of the operand ROM reader in the calculator datapath.
- Takes each finished result pair (quotient/product `saida`, remainder `saidaResto`) over a valid/ready handshake.
- Serialises the pair into byte-wide writes to a 512x8 result RAM at sequential addresses, so a later pass or the bench can read results back in program order.
- Sits after regC/RegResto. Controle pulses `res_valid` when FimC is reached.

Parameters:
- ADDR_W, 9, RAM address width (same as the ROM address width).
- BASE_ADDR, 0, first RAM byte address written after reset or clear.
- WRAP, 0, 0 = stop and assert full when space runs out; 1 = wrap to BASE_ADDR and keep writing.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous request to restart logging at BASE_ADDR.
- res_valid  in  1  result pair available.
- res_ready  out  1  block can accept a pair this cycle.
- res_saida  in  16  result word (saida).
- res_resto  in  16  remainder word (saidaResto).
- ram_we  out  1  RAM write strobe.
- ram_ready  in  1  RAM accepts the write this cycle (stall when low).
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- rec_count  out  8  number of records fully written.
- full  out  1  no room for another record (WRAP=0 only).

Behaviour:
- Reset (reset_n low, asynchronous):
  - State IDLE; ram_we=0, ram_addr=BASE_ADDR, ram_wdata=0, rec_count=0, full=0.
  - Latched words cleared; pending clear cleared.
  - A reset mid-record abandons the record; bytes already written stay in RAM.
- Record size R = 4 bytes, or 5 with CHECKSUM_EN. Byte order:
  1. saida[15:8]
  2. saida[7:0]
  3. resto[15:8]
  4. resto[7:0]
- States: IDLE, B0, B1, B2, B3 (plus CK with CHECKSUM_EN).
- res_ready = (state==IDLE) & !full & !clear & !clear_pend. This is combinational.
- Accept is res_valid & res_ready. On accept, both words are latched, state goes to B0, and `res_saida`/`res_resto` are ignored afterwards.
- In each Bn (and CK):
  - ram_we=1; ram_wdata = the selected byte; ram_addr = current pointer.
  - If ram_ready=1: pointer +1 and advance to the next state.
  - If ram_ready=0: hold state, address and data unchanged.
- Leaving the last byte state:
  - Return to IDLE; rec_count +1 (wraps modulo 256).
  - Space check on the pointer: if pointer + R > 2^ADDR_W:
    - WRAP=0: full=1 and the pointer stays.
    - WRAP=1: pointer = BASE_ADDR.
- Timing:
  - First write byte appears the cycle after accept.
  - Best-case throughput is one record per R+1 cycles.
  - res_ready reasserts the cycle after the last byte is written.
- ram_we is 0 in IDLE.
- clear:
  - In IDLE: next cycle pointer=BASE_ADDR, rec_count=0, full=0.
  - Outside IDLE: latched into clear_pend. The current record completes and is counted, then the clear is applied on the IDLE entry cycle.
  - clear together with res_valid in IDLE: clear wins and nothing is accepted.
- full is sticky until clear or reset. res_valid while full is ignored, with no write and no count change.

Optional Feature:
- Macro: CHECKSUM_EN.
- Defined:
  - R=5; a CK state follows B3 and writes the XOR of the four record bytes.
  - Full check and wrap use R=5 (WRAP=0, BASE_ADDR=0: 102 records, full after the record ending at byte 509).
- Undefined:
  - R=4, with no CK state or logic (128 records, full after address 511).

Test Plan:
- Reset then one pair saida=0x1234, resto=0x0005, ram_ready=1 -> writes 0x12@0, 0x34@1, 0x00@2, 0x05@3 on consecutive cycles starting one cycle after accept. Then rec_count=1 and res_ready=1 on the next cycle.
- Same pair with ram_ready low for 3 cycles during B1 -> ram_addr=1 and ram_wdata=0x34 held for those 3 cycles. Sequence then completes unchanged; res_ready stays 0 throughout.
- 128 back-to-back pairs with WRAP=0 -> full=1 after the record at 508..511, res_ready=0, and a 129th res_valid causes no ram_we. Then clear -> full=0, rec_count=0, next record written at address 0.
- Same run with WRAP=1 -> the 129th record is written at 0..3 and rec_count=129.
- clear asserted during B2 -> record completes through address 3 and rec_count goes 1 then 0. The next pair is written at 0. Also, clear and res_valid in the same IDLE cycle -> no accept.
- With CHECKSUM_EN, pair 0xA5A5/0x0F0F -> bytes A5, A5, 0F, 0F, 00 at addresses 0-4.
- Also with CHECKSUM_EN: reset_n low during B1 -> outputs reset immediately (asynchronous), rec_count=0.

Source files
------------

// File: rtl/gravador_resultados.sv
//==============================================================================
// Module      : gravador_resultados
// Description : Serialises (saida, resto) result pairs into byte writes to a
//               512x8 result RAM at sequential addresses. Optional checksum
//               byte per record is enabled by defining CHECKSUM_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gravador_resultados #(
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0,
    parameter bit WRAP      = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [15:0]       res_saida,
    input  logic [15:0]       res_resto,
    output logic              ram_we,
    input  logic              ram_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic [7:0]        rec_count,
    output logic              full
);

`ifdef CHECKSUM_EN
    localparam int c_rec_bytes = 5;
`else
    localparam int c_rec_bytes = 4;
`endif

    localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W+1:0] c_rec_plus1 = (ADDR_W+2)'(c_rec_bytes + 1);
    localparam logic [ADDR_W+1:0] c_space     = {2'b01, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_B3   = 3'd4
`ifdef CHECKSUM_EN
        ,
        ST_CK   = 3'd5
`endif
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_cnt;
    logic              r_full;
    logic              r_clear_pend;
    logic [15:0]       r_saida;
    logic [15:0]       r_resto;

    state_t            w_state_nxt;
    state_t            w_adv;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [7:0]        w_cnt_nxt;
    logic              w_full_nxt;
    logic              w_pend_nxt;
    logic              w_accept;
    logic              w_ready;
    logic              w_we;
    logic [7:0]        w_wdata;
    logic              w_last;
    logic [ADDR_W+1:0] w_ptr_end;

    // End (exclusive) of the next record if it started right after this byte
    assign w_ptr_end = {2'b00, r_ptr} + c_rec_plus1;

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_full_nxt  = r_full;
        w_pend_nxt  = r_clear_pend;
        w_accept    = 1'b0;
        w_we        = 1'b0;
        w_wdata     = 8'h00;
        w_last      = 1'b0;
        w_ready     = (r_state == ST_IDLE) && !r_full && !clear && !r_clear_pend;

        case (r_state)
            ST_IDLE: begin
                if (clear || r_clear_pend) begin
                    w_ptr_nxt  = c_base;
                    w_cnt_nxt  = 8'd0;
                    w_full_nxt = 1'b0;
                    w_pend_nxt = 1'b0;
                end else if (res_valid && w_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_B0;
                end
            end
            ST_B0: begin
                w_we    = 1'b1;
                w_wdata = r_saida[15:8];
                w_adv   = ST_B1;
            end
            ST_B1: begin
                w_we    = 1'b1;
                w_wdata = r_saida[7:0];
                w_adv   = ST_B2;
            end
            ST_B2: begin
                w_we    = 1'b1;
                w_wdata = r_resto[15:8];
                w_adv   = ST_B3;
            end
            ST_B3: begin
                w_we    = 1'b1;
                w_wdata = r_resto[7:0];
`ifdef CHECKSUM_EN
                w_adv   = ST_CK;
`else
                w_last  = 1'b1;
`endif
            end
`ifdef CHECKSUM_EN
            ST_CK: begin
                w_we    = 1'b1;
                w_wdata = r_saida[15:8] ^ r_saida[7:0] ^ r_resto[15:8] ^ r_resto[7:0];
                w_last  = 1'b1;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase

        // A clear seen mid-record is deferred until the record is counted
        if (r_state != ST_IDLE) begin
            w_pend_nxt = r_clear_pend || clear;
            if (ram_ready) begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = r_cnt + 8'd1;
                    if (w_ptr_end > c_space) begin
                        if (WRAP) begin
                            w_ptr_nxt = c_base;
                        end else begin
                            w_full_nxt = 1'b1;
                        end
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end else begin
                    w_state_nxt = w_adv;
                    w_ptr_nxt   = r_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= c_base;
            r_cnt        <= 8'd0;
            r_full       <= 1'b0;
            r_clear_pend <= 1'b0;
            r_saida      <= 16'h0000;
            r_resto      <= 16'h0000;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_full       <= w_full_nxt;
            r_clear_pend <= w_pend_nxt;
            if (w_accept) begin
                r_saida <= res_saida;
                r_resto <= res_resto;
            end
        end
    end

    assign res_ready = w_ready;
    assign ram_we    = w_we;
    assign ram_wdata = w_wdata;
    assign ram_addr  = r_ptr;
    assign rec_count = r_cnt;
    assign full      = r_full;

endmodule

`default_nettype wire

// File: tb/tb_gravador_resultados.sv
//==============================================================================
// Module      : tb_gravador_resultados
// Description : Bench for gravador_resultados; a stop (WRAP=0) and a wrapping
//               (WRAP=1) instance share stimulus and a record-level model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gravador_resultados;

`ifdef CHECKSUM_EN
    localparam int R = 5;
`else
    localparam int R = 4;
`endif
    localparam int AW    = 9;
    localparam int SPACE = 512;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        res_valid;
    logic        ram_ready;
    logic [15:0] res_saida;
    logic [15:0] res_resto;
    logic [1:0]  rdy_o;
    logic [1:0]  we_o;
    logic [1:0]  full_o;
    logic [AW-1:0] addr_o [2];
    logic [7:0]  wdata_o [2];
    logic [7:0]  cnt_o [2];
    bit          stall_mode = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Record-level model: next record start, record count, full flag, and
    // the expected (addr<<8 | byte) writes still to be observed
    int m_ptr  [2];
    int m_cnt  [2];
    bit m_full [2];
    int q_exp  [2][$];

    always #5 clk = ~clk;

    gravador_resultados #(.ADDR_W(AW), .BASE_ADDR(0), .WRAP(1'b0)) u_dut_stop (
        .clk(clk), .reset_n(reset_n), .clear(clear), .res_valid(res_valid),
        .res_ready(rdy_o[0]), .res_saida(res_saida), .res_resto(res_resto),
        .ram_we(we_o[0]), .ram_ready(ram_ready), .ram_addr(addr_o[0]),
        .ram_wdata(wdata_o[0]), .rec_count(cnt_o[0]), .full(full_o[0])
    );

    gravador_resultados #(.ADDR_W(AW), .BASE_ADDR(0), .WRAP(1'b1)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .res_valid(res_valid),
        .res_ready(rdy_o[1]), .res_saida(res_saida), .res_resto(res_resto),
        .ram_we(we_o[1]), .ram_ready(ram_ready), .ram_addr(addr_o[1]),
        .ram_wdata(wdata_o[1]), .rec_count(cnt_o[1]), .full(full_o[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rec_byte(input logic [15:0] s, input logic [15:0] r, input int j);
        logic [7:0] b [4];
        b = '{s[15:8], s[7:0], r[15:8], r[7:0]};
        if (j < 4) return b[j];
        return b[0] ^ b[1] ^ b[2] ^ b[3];
    endfunction

    task automatic model_accept(input logic [15:0] s, input logic [15:0] r);
        for (int i = 0; i < 2; i++) begin
            if (!m_full[i]) begin
                for (int j = 0; j < R; j++)
                    q_exp[i].push_back(((m_ptr[i] + j) << 8) | int'(rec_byte(s, r, j)));
                m_cnt[i] = (m_cnt[i] + 1) % 256;
                m_ptr[i] += R;
                if (m_ptr[i] + R > SPACE) begin
                    if (i == 1) m_ptr[i] = 0;
                    else        m_full[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_clear;
        for (int i = 0; i < 2; i++) begin
            m_ptr[i]  = 0;
            m_cnt[i]  = 0;
            m_full[i] = 1'b0;
        end
    endtask

    task automatic wait_drain;
        int n;
        n = 0;
        while ((q_exp[0].size() != 0 || q_exp[1].size() != 0) && n < 300) begin
            tick;
            n++;
        end
        if (n >= 300) begin
            check_val("drain_timeout", 32'd1, 32'd0);
            q_exp[0].delete();
            q_exp[1].delete();
        end
    endtask

    task automatic send_pair(input logic [15:0] s, input logic [15:0] r);
        wait_drain;
        #1;
        check_val("ready_stop", rdy_o[0], !m_full[0]);
        check_val("ready_wrap", rdy_o[1], !m_full[1]);
        res_valid = 1'b1;
        res_saida = s;
        res_resto = r;
        tick;
        res_valid = 1'b0;
        res_saida = 16'($urandom);
        res_resto = 16'($urandom);
        model_accept(s, r);
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        model_clear;
    endtask

    task automatic check_status(input string tag);
        wait_drain;
        tick;
        tick;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s_count%0d", tag, i), cnt_o[i], m_cnt[i]);
            check_val($sformatf("%s_full%0d", tag, i), full_o[i], m_full[i]);
            check_val($sformatf("%s_ready%0d", tag, i), rdy_o[i], !m_full[i]);
        end
    endtask

    // Write monitor: every accepted RAM write must be the next expected byte
    always @(negedge clk) begin : p_monitor
        int e;
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (we_o[i] && ram_ready) begin
                    if (q_exp[i].size() == 0) begin
                        check_val($sformatf("spurious_we%0d", i), 32'd1, 32'd0);
                    end else begin
                        e = q_exp[i].pop_front();
                        check_val($sformatf("write%0d", i), {15'd0, addr_o[i], wdata_o[i]}, e);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (stall_mode) ram_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] s;
        logic [15:0] r;
        reset_n   = 1'b0;
        clear     = 1'b0;
        res_valid = 1'b0;
        ram_ready = 1'b1;
        res_saida = 16'h0000;
        res_resto = 16'h0000;
        model_clear;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val("rst_we", we_o[i], 1'b0);
            check_val("rst_addr", addr_o[i], 9'd0);
            check_val("rst_wdata", wdata_o[i], 8'h00);
            check_val("rst_count", cnt_o[i], 8'd0);
            check_val("rst_full", full_o[i], 1'b0);
            check_val("rst_ready", rdy_o[i], 1'b1);
        end

        // Single record: bytes on consecutive cycles starting after accept
        send_pair(16'h1234, 16'h0005);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("t1_we", we_o[0], 1'b1);
            check_val("t1_addr", addr_o[0], 9'(k));
            check_val("t1_data", wdata_o[0], rec_byte(16'h1234, 16'h0005, k));
            tick;
        end
        if (R == 5) tick;
        @(negedge clk);
        check_val("t1_count", cnt_o[0], 8'd1);
        check_val("t1_ready", rdy_o[0], 1'b1);

        // Stall for three cycles while the second byte is presented
        do_clear;
        send_pair(16'h1234, 16'h0005);
        tick;
        ram_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("stall_addr", addr_o[0], 9'd1);
            check_val("stall_data", wdata_o[0], 8'h34);
            check_val("stall_ready", rdy_o[0], 1'b0);
            tick;
        end
        ram_ready = 1'b1;
        check_status("stall");

        // Clear during B2 is applied only after the record is counted
        do_clear;
        send_pair(16'hBEEF, 16'h0102);
        tick;
        tick;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        repeat (R - 3) tick;
        @(negedge clk);
        check_val("clrpend_count", cnt_o[0], 8'd1);
        check_val("clrpend_ready", rdy_o[0], 1'b0);
        tick;
        @(negedge clk);
        check_val("clrdone_count", cnt_o[0], 8'd0);
        check_val("clrdone_addr", addr_o[0], 9'd0);
        check_val("clrdone_ready", rdy_o[0], 1'b1);
        model_clear;

        // clear and res_valid together: nothing accepted
        clear     = 1'b1;
        res_valid = 1'b1;
        res_saida = 16'hDEAD;
        res_resto = 16'hBEEF;
        #1;
        check_val("clrvalid_ready0", rdy_o[0], 1'b0);
        check_val("clrvalid_ready1", rdy_o[1], 1'b0);
        tick;
        clear     = 1'b0;
        res_valid = 1'b0;
        @(negedge clk);
        check_val("clrvalid_we0", we_o[0], 1'b0);
        check_val("clrvalid_we1", we_o[1], 1'b0);
        model_clear;

        // Fill until the stop instance is full, then one more record
        do_clear;
        n = 0;
        while (!m_full[0] && n < 200) begin
            send_pair(16'($urandom), 16'($urandom));
            n++;
        end
        check_val("fill_records", n, SPACE / R);
        check_status("fill");
        send_pair(16'($urandom), 16'($urandom));
        check_status("overflow");
        do_clear;
        @(negedge clk);
        check_val("refill_full", full_o[0], 1'b0);
        check_val("refill_count", cnt_o[0], 8'd0);
        check_val("refill_ready", rdy_o[0], 1'b1);
        send_pair(16'hCAFE, 16'hF00D);
        check_status("refill");

        // Randomised records with RAM back-pressure and occasional clears
        stall_mode = 1'b1;
        send_pair(16'hA5A5, 16'h0F0F);
        for (int it = 0; it < 40; it++) begin
            s = 16'($urandom);
            r = 16'($urandom);
            send_pair(s, r);
            if ($urandom_range(0, 7) == 0) begin
                tick;
                clear = 1'b1;
                tick;
                clear = 1'b0;
                model_clear;
                wait_drain;
                tick;
            end
        end
        stall_mode = 1'b0;
        ram_ready  = 1'b1;
        check_status("random");

        // Asynchronous reset in the middle of a record
        send_pair(16'h5A5A, 16'hC3C3);
        tick;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val("arst_we", we_o[i], 1'b0);
            check_val("arst_count", cnt_o[i], 8'd0);
            check_val("arst_addr", addr_o[i], 9'd0);
            check_val("arst_full", full_o[i], 1'b0);
        end
        q_exp[0].delete();
        q_exp[1].delete();
        model_clear;
        @(negedge clk);
        reset_n = 1'b1;
        send_pair(16'h0102, 16'h0304);
        check_status("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
